pixel_stream_packer: RTL and testbench

//  Sits between the GPMC host interface and string_driver. Packs 16-bit GPMC write

---
 rtl/pixel_stream_packer_pkg.sv | 32 +++
 rtl/pixel_stream_packer_fifo.sv | 64 ++++++
 rtl/pixel_stream_packer.sv | 191 +++++++++++++++++++
 tb/tb_pixel_stream_packer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_packer_pkg
// Description : Shared GPMC register map, CTRL bit positions, pixel width,
//               output FSM state type and STATUS level saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_stream_packer_pkg;

  localparam int c_pixel_width = 24;

  // GPMC word addresses decoded by the packer
  localparam logic [15:0] c_addr_pixel  = 16'd1;
  localparam logic [15:0] c_addr_ctrl   = 16'd2;
  localparam logic [15:0] c_addr_status = 16'd3;

  // CTRL register bit positions
  localparam int c_ctrl_flush_bit   = 0;
  localparam int c_ctrl_clr_ovf_bit = 1;

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_BLANK  = 1'b1
  } state_t;

  // STATUS only has room for a 12-bit level; larger values pin at 4095
  function automatic logic [11:0] sat_level(input logic [31:0] lvl);
    return (lvl > 32'd4095) ? 12'hFFF : lvl[11:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_stream_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous pixel FIFO with synchronous flush and async reset.
//               A push into a full FIFO is accepted only when a pop happens in
//               the same cycle; callers only pop when not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q;
  logic [c_aw-1:0]  rd_ptr_q;
  logic [c_aw:0]    count_q;
  logic             w_wr;
  logic             w_rd;

  assign full_o  = (count_q == (c_aw+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign w_rd    = pop_i && !empty_o && !flush_i;
  assign w_wr    = push_i && !flush_i && (!full_o || w_rd);

  // Storage array; no reset needed since reads are gated by the count
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{c_aw{1'b0}}, w_wr} - {{c_aw{1'b0}}, w_rd};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_packer
// Description : Packs 16-bit GPMC PIXEL writes into 24-bit GRB pixels, queues
//               them and releases one per pixel_ready, inserting an h_blank
//               gap after every string. Hosts the CTRL/STATUS registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int PIXEL_WIDTH       = c_pixel_width,
  parameter int FIFO_DEPTH        = 64,
  parameter int PIXELS_PER_STRING = 150,
  parameter int BLANK_CYCLES      = 8000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  input  logic                   pixel_ready_i,
  output logic [PIXEL_WIDTH-1:0] pixel_data_o,
  output logic                   pixel_data_valid_o,
  output logic                   h_blank_o,
  output logic                   overflow_o
);

  localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;
  localparam int c_cnt_w = $clog2(PIXELS_PER_STRING + 1);
  localparam int c_blk_w = $clog2(BLANK_CYCLES + 1);

  // Register decode
  logic w_pix_wr, w_ctrl_wr, w_flush, w_clr_ovf;
  assign w_pix_wr  = wr_en_i && (address_i == ADDR_WIDTH'(c_addr_pixel));
  assign w_ctrl_wr = wr_en_i && (address_i == ADDR_WIDTH'(c_addr_ctrl));
  assign w_flush   = w_ctrl_wr && wr_data_i[c_ctrl_flush_bit];
  assign w_clr_ovf = w_ctrl_wr && wr_data_i[c_ctrl_clr_ovf_bit];

  // rd_en is not needed: STATUS is a side-effect-free combinational read
  logic w_unused;
  assign w_unused = rd_en_i;

  // Packer state
  logic [1:0]             phase_q, phase_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   w_push;
  logic [PIXEL_WIDTH-1:0] w_push_data;

  // FIFO interface
  logic [PIXEL_WIDTH-1:0] w_head;
  logic                   w_full, w_empty, w_pop, w_drop;
  logic [c_lvl_w-1:0]     w_level;

  // Output FSM state and registered outputs
  state_t                 state_q;
  logic [c_cnt_w-1:0]     cnt_q;
  logic [c_blk_w-1:0]     blank_q;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic                   valid_q, hblank_q, ovf_q;

  // Three halfwords carry two pixels: ph0 stashes, ph1 and ph2 each emit one
  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    w_push      = 1'b0;
    w_push_data = '0;
    if (w_flush) begin
      phase_d = 2'd0;
    end else if (w_pix_wr) begin
      case (phase_q)
        2'd0: begin
          hold_d  = wr_data_i;
          phase_d = 2'd1;
        end
        2'd1: begin
          w_push      = 1'b1;
          w_push_data = {hold_q, wr_data_i[15:8]};
          hold_d[7:0] = wr_data_i[7:0];
          phase_d     = 2'd2;
        end
        default: begin
          w_push      = 1'b1;
          w_push_data = {hold_q[7:0], wr_data_i};
          phase_d     = 2'd0;
        end
      endcase
    end
  end

  // Packer phase and partial-pixel holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 2'd0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

  assign w_pop  = (state_q == ST_STREAM) && pixel_ready_i && !w_empty && !w_flush;
  assign w_drop = w_push && w_full && !w_pop;

  pixel_fifo #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (w_flush),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (w_level)
  );

  // Sticky overflow; a drop wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_q <= 1'b0;
    else if (w_drop)    ovf_q <= 1'b1;
    else if (w_clr_ovf) ovf_q <= 1'b0;
  end

  // Output FSM: stream a string of pixels, then hold h_blank for the gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STREAM;
      cnt_q    <= '0;
      blank_q  <= '0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
      hblank_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (w_flush) begin
        cnt_q    <= '0;
        blank_q  <= '0;
        state_q  <= ST_BLANK;
        hblank_q <= 1'b1;
      end else begin
        case (state_q)
          ST_STREAM: begin
            if (w_pop) begin
              pix_q   <= w_head;
              valid_q <= 1'b1;
              if (cnt_q == c_cnt_w'(PIXELS_PER_STRING - 1)) begin
                cnt_q    <= '0;
                blank_q  <= '0;
                state_q  <= ST_BLANK;
                hblank_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          ST_BLANK: begin
            if (blank_q == c_blk_w'(BLANK_CYCLES - 1)) begin
              state_q  <= ST_STREAM;
              hblank_q <= 1'b0;
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          default: state_q <= ST_STREAM;
        endcase
      end
    end
  end

  assign pixel_data_o       = pix_q;
  assign pixel_data_valid_o = valid_q;
  assign h_blank_o          = hblank_q;
  assign overflow_o         = ovf_q;

  // STATUS read decode
  always_comb begin
    rd_data_o = '0;
    if (address_i == ADDR_WIDTH'(c_addr_status))
      rd_data_o = DATA_WIDTH'({ovf_q, phase_q, 1'b0, sat_level(32'(w_level))});
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_packer
// Description : Self-checking bench for pixel_stream_packer with a queue-based
//               reference model compared every cycle plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_packer;

  localparam int DEPTH = 4;
  localparam int PPS   = 4;
  localparam int BC    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, pixel_ready;
  logic [15:0] address, wr_data;
  logic [15:0] rd_data;
  logic [23:0] pixel_data;
  logic        pixel_valid, h_blank, overflow;

  pixel_stream_packer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .PIXEL_WIDTH(24),
    .FIFO_DEPTH(DEPTH), .PIXELS_PER_STRING(PPS), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .address_i(address), .wr_data_i(wr_data), .rd_data_o(rd_data),
    .pixel_ready_i(pixel_ready), .pixel_data_o(pixel_data),
    .pixel_data_valid_o(pixel_valid), .h_blank_o(h_blank), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] mq[$];
  int          m_phase = 0, m_left = 0, m_cnt = 0;
  logic [15:0] m_hold = 0;
  logic [23:0] m_pix = 0, m_px, m_head;
  bit          m_ovf = 0, m_blank = 0, m_valid = 0;
  bit          m_pwr, m_flush, m_clr, m_pop, m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_phase = 0; m_hold = 0; m_ovf = 0; m_blank = 0; m_valid = 0;
      m_left = 0; m_cnt = 0; m_pix = 0;
    end else begin
      m_pwr   = wr_en && address == 16'd1;
      m_flush = wr_en && address == 16'd2 && wr_data[0];
      m_clr   = wr_en && address == 16'd2 && wr_data[1];
      m_pop   = !m_blank && pixel_ready && mq.size() > 0 && !m_flush;
      m_push  = 0;
      m_valid = 0;
      if (m_pop) m_head = mq.pop_front();
      if (m_pwr && !m_flush) begin
        if (m_phase == 0) m_hold = wr_data;
        else if (m_phase == 1) begin
          m_px = {m_hold, wr_data[15:8]}; m_push = 1; m_hold[7:0] = wr_data[7:0];
        end else begin
          m_px = {m_hold[7:0], wr_data}; m_push = 1;
        end
        m_phase = (m_phase + 1) % 3;
      end
      if (m_clr) m_ovf = 0;
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_px);
        else m_ovf = 1;
      end
      if (m_flush) begin
        mq.delete(); m_phase = 0; m_cnt = 0; m_blank = 1; m_left = BC;
      end else if (m_blank) begin
        m_left--;
        if (m_left == 0) m_blank = 0;
      end else if (m_pop) begin
        m_valid = 1; m_pix = m_head; m_cnt++;
        if (m_cnt == PPS) begin m_cnt = 0; m_blank = 1; m_left = BC; end
      end
    end
  end

  function automatic logic [15:0] exp_rd();
    if (address != 16'd3) return 16'h0;
    return {m_ovf, 2'(m_phase), 1'b0, 12'(mq.size())};
  endfunction

  // ---------------- monitors ----------------
  int          cyc = 0;
  bit          rdy_s = 0;
  logic [23:0] log_px[$];
  int          log_cyc[$];
  int          runs[$];
  int          run = 0;
  int          bad_ready = 0;

  always @(posedge clk) begin
    cyc++;
    rdy_s = pixel_ready;
  end

  // Every-cycle comparison against the model, plus strobe/blank logging
  always @(negedge clk) begin
    chk("valid",      {31'b0, pixel_valid}, {31'b0, m_valid});
    chk("h_blank",    {31'b0, h_blank},     {31'b0, m_blank});
    chk("overflow",   {31'b0, overflow},    {31'b0, m_ovf});
    chk("pixel_data", {8'b0, pixel_data},   {8'b0, m_pix});
    chk("rd_data",    {16'b0, rd_data},     {16'b0, exp_rd()});
    if (pixel_valid === 1'b1) begin
      log_px.push_back(pixel_data);
      log_cyc.push_back(cyc);
      if (!rdy_s) bad_ready++;
    end
    if (h_blank === 1'b1) run++;
    else if (run > 0) begin runs.push_back(run); run = 0; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; address = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_pair(input logic [23:0] a, input logic [23:0] b);
    wr(16'd1, a[23:8]);
    wr(16'd1, {a[7:0], b[23:16]});
    wr(16'd1, b[15:0]);
  endtask

  task automatic wait_blank_end();
    for (int i = 0; i < BC + 10; i++) begin
      if (h_blank !== 1'b1) break;
      tick();
    end
    chk("blank_end_bound", {31'b0, h_blank}, 32'd0);
  endtask

  task automatic flush_wait();
    wr(16'd2, 16'h0001);
    wait_blank_end();
    idle(2);
  endtask

  task automatic clear_logs();
    log_px.delete(); log_cyc.delete(); runs.delete(); bad_ready = 0;
  endtask

  logic [23:0] pp [0:9];
  int          t_w2;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; address = 0; wr_data = 0; pixel_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    address = 16'd3; #1;
    chk("rst_rd_data", {16'b0, rd_data}, 32'h0);
    chk("rst_valid",   {31'b0, pixel_valid}, 32'd0);
    chk("rst_h_blank", {31'b0, h_blank}, 32'd0);
    chk("rst_pixel",   {8'b0, pixel_data}, 32'd0);
    tick();

    // Basic packing and latency
    clear_logs();
    pixel_ready = 1'b1;
    wr(16'd1, 16'hABCD);
    t_w2 = cyc;
    wr(16'd1, 16'hEF01);
    wr(16'd1, 16'h2345);
    idle(5);
    chk("t1_count",   log_px.size(), 32'd2);
    chk("t1_px0",     {8'b0, log_px[0]}, 32'hABCDEF);
    chk("t1_px1",     {8'b0, log_px[1]}, 32'h012345);
    chk("t1_latency", log_cyc[0] - t_w2, 32'd2);

    // Flush mid-pixel
    pixel_ready = 1'b0;
    wr(16'd1, 16'h1122);
    wr(16'd1, 16'h3344);
    wr(16'd2, 16'h0001);
    address = 16'd3; #1;
    chk("flush_status",  {16'b0, rd_data}, 32'h0);
    chk("flush_h_blank", {31'b0, h_blank}, 32'd1);
    wait_blank_end();
    clear_logs();
    pixel_ready = 1'b1;
    wr_pair(24'hA1B2C3, 24'hD4E5F6);
    idle(4);
    chk("flush_clean_px", {8'b0, log_px[0]}, 32'hA1B2C3);

    // String of PPS pixels, blank gap, next string
    flush_wait();
    clear_logs();
    pp[0] = 24'h100001; pp[1] = 24'h200002; pp[2] = 24'h300003; pp[3] = 24'h400004;
    pp[4] = 24'h500005; pp[5] = 24'h600006; pp[6] = 24'h700007; pp[7] = 24'h800008;
    for (int i = 0; i < 4; i++) wr_pair(pp[2*i], pp[2*i+1]);
    idle(BC + 40);
    chk("pps_count", log_px.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_px.size(); i++)
      chk($sformatf("pps_px%0d", i), {8'b0, log_px[i]}, {8'b0, pp[i]});
    chk("pps_blank_len", (runs.size() > 0) ? runs[0] : -1, BC);
    if (log_cyc.size() >= 5)
      chk("pps_gap", log_cyc[4] - log_cyc[3], BC + 1);
    else
      chk("pps_gap_strobes", log_cyc.size(), 32'd5);

    // Overflow on a full FIFO and clear via CTRL
    flush_wait();
    pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr_pair(24'h0A0B0C + 24'(i), 24'h0D0E0F + 24'(i));
    address = 16'd3; #1;
    chk("ovf_status", {16'b0, rd_data}, 32'h8004);
    wr(16'd2, 16'h0002);
    address = 16'd3; #1;
    chk("ovf_cleared", {16'b0, rd_data}, 32'h0004);

    // Async reset mid-blank with a non-empty FIFO
    pixel_ready = 1'b1;
    idle(10);
    chk("rst_pre_blank", {31'b0, h_blank}, 32'd1);
    pixel_ready = 1'b0;
    wr_pair(24'h123456, 24'h789ABC);
    address = 16'd3;
    #2 rst = 1'b1;
    #1;
    chk("arst_pixel",   {8'b0, pixel_data}, 32'd0);
    chk("arst_valid",   {31'b0, pixel_valid}, 32'd0);
    chk("arst_h_blank", {31'b0, h_blank}, 32'd0);
    chk("arst_ovf",     {31'b0, overflow}, 32'd0);
    chk("arst_rd_data", {16'b0, rd_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("arst_level", {16'b0, rd_data}, 32'd0);

    // pixel_ready toggling every cycle
    clear_logs();
    for (int i = 0; i < 10; i++) pp[i] = 24'hC00000 + 24'(i * 24'h010101);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          wr_pair(pp[2*i], pp[2*i+1]);
          idle(25);
        end
      end
      begin
        repeat (260) begin
          tick();
          pixel_ready = ~pixel_ready;
        end
      end
    join
    chk("tog_count", log_px.size(), 32'd10);
    for (int i = 0; i < 10 && i < log_px.size(); i++)
      chk($sformatf("tog_px%0d", i), {8'b0, log_px[i]}, {8'b0, pp[i]});
    chk("tog_no_pop_unready", bad_ready, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
